// File: rtl/cva6_fifo_credit_sender.sv
// Push-side controller for a remote FIFO: registers a valid/ready stream onto push_o/data_o
// and tracks returned credits so the remote FIFO is never pushed while full.
module cva6_fifo_credit_sender #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned CREDIT_LAT = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  dtype                         data_i,
    output logic                         push_o,
    output dtype                         data_o,
    input  logic                         credit_i,
    output logic [$clog2(DEPTH+1)-1:0]   credits_o,
    output logic                         idle_o,
    output logic                         err_o
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned FCNT_W = $clog2(CREDIT_LAT + 2);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [FCNT_W-1:0] LAT_C   = FCNT_W'(CREDIT_LAT);

    typedef enum logic {
        ACTIVE,
        FLUSH
    } state_e;

    state_e              state_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic [CNT_W-1:0]    credits_q;
    logic                accept;

    assign ready_o   = (state_q == ACTIVE) && (credits_q != '0);
    assign accept    = valid_i && ready_o;
    assign credits_o = credits_q;
    assign idle_o    = (state_q == ACTIVE) && (credits_q == DEPTH_C) && !push_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ACTIVE;
            fcnt_q    <= '0;
            credits_q <= DEPTH_C;
            push_o    <= 1'b0;
            data_o    <= '0;
            err_o     <= 1'b0;
        end else begin
            // Upstream is expected to stall for the whole drain window.
            if ((state_q == FLUSH) && valid_i) begin
                err_o <= 1'b1;
            end
            if (flush_i) begin
                // The remote FIFO empties with us, so every credit is ours again;
                // an accept in this cycle is dropped rather than pushed.
                state_q   <= FLUSH;
                fcnt_q    <= LAT_C;
                credits_q <= DEPTH_C;
                push_o    <= 1'b0;
            end else if (state_q == FLUSH) begin
                // Credits still in the return pipe belong to pre-flush pops; ignore them.
                push_o <= 1'b0;
                if (fcnt_q == '0) begin
                    state_q <= ACTIVE;
                end else begin
                    fcnt_q <= fcnt_q - FCNT_W'(1);
                end
            end else begin
                push_o <= accept;
                if (accept) begin
                    data_o <= data_i;
                end
                if (credit_i && !accept && (credits_q == DEPTH_C)) begin
                    err_o <= 1'b1;
                end else begin
                    credits_q <= credits_q - CNT_W'(accept) + CNT_W'(credit_i);
                end
            end
        end
    end

`ifndef SYNTHESIS
    if (DEPTH < 1) begin : g_depth_check
        $error("cva6_fifo_credit_sender: DEPTH must be >= 1");
    end

    // A push is only ever issued against a free slot in the remote FIFO.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (credits_q != '0));

    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        credits_q <= DEPTH_C);
`endif

endmodule

// File: tb/tb_cva6_fifo_credit_sender.sv
// Bench for cva6_fifo_credit_sender: vector table, flush/reset corner sequences and a
// randomized run against a remote-FIFO model with delayed credit return.
module tb_cva6_fifo_credit_sender;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic        push_o;
    logic [31:0] data_o;
    logic        credit_i = 1'b0;
    logic [3:0]  credits_o;
    logic        idle_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    cva6_fifo_credit_sender #(
        .DEPTH(DEPTH), .DATA_WIDTH(32), .CREDIT_LAT(LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_i(data_i), .push_o(push_o), .data_o(data_o),
        .credit_i(credit_i), .credits_o(credits_o), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush, valid, credit;
        logic [31:0] data;
        logic        e_push;
        logic [3:0]  e_cred;
        logic        e_ready, e_idle, e_err;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        flush_i = 0; valid_i = 0; credit_i = 0; data_i = '0;
        tick();
        rst_ni = 0;
        tick();
        rst_ni = 1;
    endtask

    task automatic add(input logic f, input logic v, input logic c, input logic [31:0] d,
                       input logic ep, input int ec, input logic er, input logic ei,
                       input logic ee, input logic [31:0] ed);
        vec_t r;
        r.flush = f; r.valid = v; r.credit = c; r.data = d;
        r.e_push = ep; r.e_cred = 4'(ec); r.e_ready = er; r.e_idle = ei;
        r.e_err = ee; r.e_data = ed;
        tbl.push_back(r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] expq[$];
        logic [31:0] fifo[$];
        bit          dl[$];
        int          mcred;
        bit          pop;

        // Reset state
        do_reset();
        chk("reset credits", credits_o, 8);
        chk("reset ready", ready_o, 1);
        chk("reset push", push_o, 0);
        chk("reset idle", idle_o, 1);
        chk("reset err", err_o, 0);
        chk("reset data", data_o, 0);

        // Fill, stall, single credit, simultaneous accept+credit, overflow
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 32'h100 + i, 1, 7 - i, (i != 7), 0, 0, 32'h100 + i);
        add(0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h107);
        add(0, 0, 1, 32'h0,    0, 1, 1, 0, 0, 32'h107);
        add(0, 1, 0, 32'h55,   1, 0, 0, 0, 0, 32'h55);
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 32'h0, 0, i + 1, 1, 0, 0, 32'h55);
        add(0, 1, 1, 32'h77, 1, 3, 1, 0, 0, 32'h77);
        add(0, 0, 0, 32'h0,  0, 3, 1, 0, 0, 32'h77);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 32'h0, 0, 4 + i, 1, (i == 4), 0, 32'h77);
        add(0, 0, 1, 32'h0, 0, 8, 1, 1, 1, 32'h77);
        add(0, 0, 0, 32'h0, 0, 8, 1, 1, 1, 32'h77);

        for (int i = 0; i < tbl.size(); i++) begin
            flush_i = tbl[i].flush; valid_i = tbl[i].valid;
            credit_i = tbl[i].credit; data_i = tbl[i].data;
            tick();
            chk($sformatf("row%0d push", i),    push_o,    tbl[i].e_push);
            chk($sformatf("row%0d credits", i), credits_o, tbl[i].e_cred);
            chk($sformatf("row%0d ready", i),   ready_o,   tbl[i].e_ready);
            chk($sformatf("row%0d idle", i),    idle_o,    tbl[i].e_idle);
            chk($sformatf("row%0d err", i),     err_o,     tbl[i].e_err);
            chk($sformatf("row%0d data", i),    data_o,    tbl[i].e_data);
        end
        flush_i = 0; valid_i = 0; credit_i = 0;

        // err_o survives a flush and clears only on reset
        flush_i = 1; tick(); flush_i = 0;
        repeat (4) tick();
        chk("err sticky after flush", err_o, 1);
        do_reset();
        chk("err cleared by reset", err_o, 0);

        // Flush with 5 credits outstanding; flush-cycle accept must be killed
        for (int i = 0; i < 5; i++) begin
            valid_i = 1; data_i = 32'h200 + i; tick();
        end
        chk("pre-flush credits", credits_o, 3);
        chk("pre-flush push", push_o, 1);
        flush_i = 1; valid_i = 1; data_i = 32'hBAD; tick();
        flush_i = 0; valid_i = 0;
        chk("flush credits restored", credits_o, 8);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("flush c%0d push", k), push_o, 0);
            chk($sformatf("flush c%0d ready", k), ready_o, 0);
            credit_i = 1; tick();
        end
        credit_i = 0;
        chk("post-flush ready", ready_o, 1);
        chk("post-flush credits", credits_o, 8);
        chk("post-flush idle", idle_o, 1);
        chk("post-flush err", err_o, 0);
        chk("post-flush data held", data_o, 32'h204);

        // valid_i while draining is an error
        flush_i = 1; tick(); flush_i = 0;
        valid_i = 1; tick(); valid_i = 0;
        chk("valid in flush err", err_o, 1);
        repeat (4) tick();

        // Asynchronous reset mid-operation drops the pending push
        do_reset();
        valid_i = 1; data_i = 32'h3C3C; tick(); valid_i = 0;
        chk("mid push before reset", push_o, 1);
        rst_ni = 0; #1;
        chk("async reset push", push_o, 0);
        chk("async reset credits", credits_o, 8);
        chk("async reset data", data_o, 0);
        chk("async reset ready", ready_o, 1);
        tick();
        rst_ni = 1;
        tick();

        // Randomized run against a remote FIFO with delayed credit return
        mcred = DEPTH;
        for (int i = 0; i < LAT; i++) dl.push_back(1'b0);
        for (int c = 0; c < 10000; c++) begin
            chk("rnd credits", credits_o, mcred);
            chk("rnd ready", ready_o, (mcred != 0));
            pop = (fifo.size() != 0) && ($urandom_range(0, 3) != 0);
            if (pop) void'(fifo.pop_front());
            if (push_o) begin
                if (expq.size() == 0) chk("rnd spurious push", 1, 0);
                else chk("rnd data order", data_o, expq.pop_front());
                fifo.push_back(data_o);
                if (fifo.size() > DEPTH) chk("rnd remote overflow", fifo.size(), DEPTH);
            end
            dl.push_back(pop);
            credit_i = dl.pop_front();
            valid_i  = 1'($urandom_range(0, 1));
            data_i   = $urandom;
            if (valid_i && mcred != 0) begin
                expq.push_back(data_i);
                mcred--;
            end
            if (credit_i) mcred++;
            tick();
        end
        valid_i = 0; credit_i = 0;
        chk("rnd no error", err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
